// File: rtl/sdram_pkg.sv
// Shared command encodings, init states and address geometry for the SDRAM responder.
// Latency: n/a (package). Backpressure: n/a.
// Build option: SDRAM_RESP_CHECK_EN (used by sdram_responder) enables protocol checking.
package sdram_pkg;

    localparam int ROW_WIDTH  = 13;
    localparam int COL_WIDTH  = 9;
    localparam int BANK_WIDTH = 2;
    localparam int NUM_BANKS  = 1 << BANK_WIDTH;

    // CAS latency in cycles; only 2 and 3 are supported.
    localparam logic [1:0] CL_DEFAULT = 2'd3;

    // {ras_n, cas_n, we_n}
    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_NOP   = 3'b111
    } cmd_e;

    typedef enum logic [1:0] {
        ST_WAIT_PALL = 2'd0,
        ST_WAIT_REF  = 2'd1,
        ST_WAIT_MRS  = 2'd2,
        ST_READY     = 2'd3
    } init_state_e;

    // A mode register write is accepted only for CL 2/3 with burst length field 000.
    function automatic logic mrs_valid(input logic [2:0] cl, input logic [2:0] bl);
        return ((cl == 3'd2) || (cl == 3'd3)) && (bl == 3'd0);
    endfunction

endpackage

// File: rtl/sdram_resp_cas_pipe.sv
// CAS latency pipeline: carries read data + valid, output tap chosen by CL (2 or 3).
// Latency: CL cycles from in_vld_i edge to out_vld_o. Backpressure: none, accepts one read per edge.
// Ports: clk/rst, in_vld_i/in_dat_i (read captured at command edge), cl_i, out_vld_o/out_dat_o.
module sdram_resp_cas_pipe #(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_vld_i,
    input  logic [DW-1:0] in_dat_i,
    input  logic [1:0]    cl_i,
    output logic          out_vld_o,
    output logic [DW-1:0] out_dat_o
);

    localparam int DEPTH = 3;

    logic [DEPTH-1:0] vld_q;
    logic [DW-1:0]    dat_q [DEPTH];

    // Only the valid bits need flushing; data is qualified by them.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= {vld_q[DEPTH-2:0], in_vld_i};
        end
    end

    always_ff @(posedge clk) begin
        dat_q[0] <= in_dat_i;
        for (int i = 1; i < DEPTH; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    // Stage n holds a read issued n+1 edges ago, so CL selects stage CL-1.
    always_comb begin
        out_vld_o = vld_q[2];
        out_dat_o = dat_q[2];
        if (cl_i == 2'd2) begin
            out_vld_o = vld_q[1];
            out_dat_o = dat_q[1];
        end
    end

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device-side responder: init FSM, per-bank open rows, 16-bit storage, CL-delayed reads.
// Latency: read data on dq_out for the cycle between edges k+CL-1 and k+CL. Backpressure: none.
// Ports: clk/rst, SDRAM command pins, addr/bank_addr, byte masks, dq_in/dq_out/dq_oe, init_done, err.
// Build option: SDRAM_RESP_CHECK_EN adds tRCD/bank-state checking and a sticky err flag.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int MEM_AW = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clock_enable,
    input  logic                  cs_n,
    input  logic                  ras_n,
    input  logic                  cas_n,
    input  logic                  we_n,
    input  logic [ROW_WIDTH-1:0]  addr,
    input  logic [BANK_WIDTH-1:0] bank_addr,
    input  logic                  data_mask_low,
    input  logic                  data_mask_high,
    input  logic [15:0]           dq_in,
    output logic [15:0]           dq_out,
    output logic                  dq_oe,
    output logic                  init_done,
    output logic                  err
);

    localparam int MEM_WORDS = 1 << MEM_AW;

    // ---------------- command decode ----------------
    logic [2:0] pins;
    cmd_e       cmd;

    assign pins = {ras_n, cas_n, we_n};

    // Burst terminate (110) is not modelled and decodes as NOP.
    always_comb begin
        cmd = CMD_NOP;
        if (clock_enable && !cs_n && (pins != 3'b110)) begin
            cmd = cmd_e'(pins);
        end
    end

    logic mrs_ok;
    assign mrs_ok = mrs_valid(addr[6:4], addr[2:0]);

    // ---------------- init FSM ----------------
    init_state_e state_q, state_d;
    logic        ref_seen_q, ref_seen_d;
    logic        ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_WAIT_PALL;
            ref_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ref_seen_q <= ref_seen_d;
        end
    end

    // Anything other than the expected command leaves the state untouched.
    always_comb begin
        state_d    = state_q;
        ref_seen_d = ref_seen_q;
        case (state_q)
            ST_WAIT_PALL: if (cmd == CMD_PRE && addr[10]) state_d = ST_WAIT_REF;
            ST_WAIT_REF: begin
                if (cmd == CMD_REF) begin
                    ref_seen_d = !ref_seen_q;
                    if (ref_seen_q) state_d = ST_WAIT_MRS;
                end
            end
            ST_WAIT_MRS: if (cmd == CMD_MRS && mrs_ok) state_d = ST_READY;
            default: ;
        endcase
    end

    always_comb begin
        ready     = (state_q == ST_READY);
        init_done = ready;
    end

    // ---------------- bank state / storage ----------------
    logic [NUM_BANKS-1:0] bank_open_q;
    logic [ROW_WIDTH-1:0] bank_row_q [NUM_BANKS];
    logic [1:0]           cl_q;
    logic                 access_ok, act_ok, act_fire, do_write, do_read, mrs_take;
    logic [MEM_AW-1:0]    mem_idx;
    logic [15:0]          mem [MEM_WORDS];

    assign act_fire = ready && (cmd == CMD_ACT) && act_ok;
    assign do_write = ready && !rst && (cmd == CMD_WRITE) && access_ok;
    assign do_read  = ready && (cmd == CMD_READ) && access_ok;
    assign mrs_take = (cmd == CMD_MRS) && (ready || (state_q == ST_WAIT_MRS));

    // Rows are cleared on close, so a closed bank addresses row 0.
    assign mem_idx = MEM_AW'({bank_addr, bank_row_q[bank_addr], addr[COL_WIDTH-1:0]});

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_open_q <= '0;
            cl_q        <= CL_DEFAULT;
            for (int b = 0; b < NUM_BANKS; b++) bank_row_q[b] <= '0;
        end else begin
            if (mrs_take) cl_q <= mrs_ok ? addr[5:4] : CL_DEFAULT;
            if (act_fire) begin
                bank_open_q[bank_addr] <= 1'b1;
                bank_row_q[bank_addr]  <= addr;
            end
            if ((do_read || do_write) && addr[10]) begin
                bank_open_q[bank_addr] <= 1'b0;
                bank_row_q[bank_addr]  <= '0;
            end
            if (ready && cmd == CMD_PRE) begin
                if (addr[10]) begin
                    bank_open_q <= '0;
                    for (int b = 0; b < NUM_BANKS; b++) bank_row_q[b] <= '0;
                end else begin
                    bank_open_q[bank_addr] <= 1'b0;
                    bank_row_q[bank_addr]  <= '0;
                end
            end
        end
    end

    // Storage is deliberately outside reset so contents survive re-init.
    always_ff @(posedge clk) begin
        if (do_write) begin
            if (!data_mask_low)  mem[mem_idx][7:0]  <= dq_in[7:0];
            if (!data_mask_high) mem[mem_idx][15:8] <= dq_in[15:8];
        end
    end

    // ---------------- read pipeline ----------------
    logic        pipe_vld;
    logic [15:0] pipe_dat;

    // Read word is captured at the command edge; later writes cannot disturb it.
    sdram_resp_cas_pipe #(.DW(16)) u_cas_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_vld_i  (do_read),
        .in_dat_i  (mem[mem_idx]),
        .cl_i      (cl_q),
        .out_vld_o (pipe_vld),
        .out_dat_o (pipe_dat)
    );

    assign dq_oe  = pipe_vld;
    assign dq_out = pipe_vld ? pipe_dat : 16'h0000;

    // ---------------- protocol checking ----------------
`ifdef SDRAM_RESP_CHECK_EN
    logic [1:0] trcd_q [NUM_BANKS];
    logic       init_bad, err_set, err_q;

    // A counter of 1 reaches 0 at this edge, making CAS at ACT+2 legal.
    assign access_ok = bank_open_q[bank_addr] && (trcd_q[bank_addr] <= 2'd1);
    assign act_ok    = !bank_open_q[bank_addr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) trcd_q[b] <= 2'd0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (act_fire && bank_addr == BANK_WIDTH'(b)) trcd_q[b] <= 2'd2;
                else if (trcd_q[b] != 2'd0)                  trcd_q[b] <= trcd_q[b] - 2'd1;
            end
        end
    end

    always_comb begin
        init_bad = 1'b0;
        case (state_q)
            ST_WAIT_PALL: init_bad = (cmd != CMD_NOP) && !(cmd == CMD_PRE && addr[10]);
            ST_WAIT_REF:  init_bad = (cmd != CMD_NOP) && (cmd != CMD_REF);
            ST_WAIT_MRS:  init_bad = (cmd != CMD_NOP) && !(cmd == CMD_MRS && mrs_ok);
            default:      init_bad = 1'b0;
        endcase
    end

    always_comb begin
        err_set = init_bad;
        if (ready) begin
            case (cmd)
                CMD_ACT:             err_set = !act_ok;
                CMD_READ, CMD_WRITE: err_set = !access_ok;
                CMD_REF:             err_set = |bank_open_q;
                CMD_MRS:             err_set = !mrs_ok;
                default:             err_set = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          err_q <= 1'b0;
        else if (err_set) err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign access_ok = 1'b1;
    assign act_ok    = 1'b1;
    assign err       = 1'b0;
`endif

endmodule
